ctrl_pipe: RTL and testbench



---
 rtl/ctrl_pipe_if.sv | 51 +++++
 rtl/ctrl_pipe.sv | 180 ++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if
// Groups the control-pipeline signals between the decode side and ctrl_pipe.
//   ID side (driven by master):  id_valid, id_ctrl[8:0], id_rs1/id_rs2/id_rd[4:0],
//                                ex_redirect, hold
//   Pipe side (driven by slave): stall, ex/mem/wb valid, ex_ctrl[8:0],
//                                ex_rs1/ex_rs2/ex_rd, mem_* controls + mem_rd,
//                                wb_* controls + wb_rd, fwd_a/fwd_b[1:0]
// Bundle bit map: [8] RegWrite [7] MemRead [6] MemWrite [5] MemtoReg
//                 [4] ALUSrc [3] Branch [2] Jump [1:0] ALUOp
interface ctrl_pipe_if;
  logic       id_valid;
  logic [8:0] id_ctrl;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       ex_redirect;
  logic       hold;

  logic       stall;
  logic       ex_valid;
  logic       mem_valid;
  logic       wb_valid;
  logic [8:0] ex_ctrl;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic [4:0] ex_rd;
  logic       mem_reg_write;
  logic       mem_mem_read;
  logic       mem_mem_write;
  logic       mem_mem_to_reg;
  logic [4:0] mem_rd;
  logic       wb_reg_write;
  logic       wb_mem_to_reg;
  logic [4:0] wb_rd;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  modport master (
    output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_redirect, hold,
    input  stall, ex_valid, mem_valid, wb_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_rd,
           wb_reg_write, wb_mem_to_reg, wb_rd, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_redirect, hold,
    output stall, ex_valid, mem_valid, wb_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_rd,
           wb_reg_write, wb_mem_to_reg, wb_rd, fwd_a, fwd_b
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe
// Carries the decoded control bundle from ID through EX, MEM and WB of the
// 5-stage RV32I pipeline, detects load-use hazards (IF/ID stall), inserts
// bubbles on stall or taken branch/jump, and produces EX forwarding selects.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears every stage register
//   bus    ctrl_pipe_if.slave: ID inputs, redirect/hold, stage outputs, fwd selects
module ctrl_pipe (
  input  logic         clk,
  input  logic         reset,
  ctrl_pipe_if.slave   bus
);

  // ID->EX stage register
  logic       ex_valid_q, ex_valid_d;
  logic [8:0] ex_ctrl_q,  ex_ctrl_d;
  logic [4:0] ex_rs1_q,   ex_rs1_d;
  logic [4:0] ex_rs2_q,   ex_rs2_d;
  logic [4:0] ex_rd_q,    ex_rd_d;

  // EX->MEM stage register
  logic       mem_valid_q, mem_valid_d;
  logic       mem_rw_q,    mem_rw_d;
  logic       mem_mr_q,    mem_mr_d;
  logic       mem_mw_q,    mem_mw_d;
  logic       mem_mtr_q,   mem_mtr_d;
  logic [4:0] mem_rd_q,    mem_rd_d;

  // MEM->WB stage register
  logic       wb_valid_q, wb_valid_d;
  logic       wb_rw_q,    wb_rw_d;
  logic       wb_mtr_q,   wb_mtr_d;
  logic [4:0] wb_rd_q,    wb_rd_d;

  logic       stall_w;
  logic       mem_reg_write_w;
  logic       wb_reg_write_w;

  // Load-use hazard: the load in EX has not produced data yet, so the
  // dependent instruction in ID must wait one cycle. A redirect squashes ID
  // anyway, so the stall is suppressed then.
  always_comb begin
    stall_w = bus.id_valid & ex_valid_q & ex_ctrl_q[7] & (ex_rd_q != 5'd0) &
              ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2)) &
              ~bus.ex_redirect;
  end

  // Next-state for all stages. hold freezes everything; otherwise MEM and WB
  // always advance and EX either captures ID or takes a bubble.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_rd_d     = ex_rd_q;
    mem_valid_d = mem_valid_q;
    mem_rw_d    = mem_rw_q;
    mem_mr_d    = mem_mr_q;
    mem_mw_d    = mem_mw_q;
    mem_mtr_d   = mem_mtr_q;
    mem_rd_d    = mem_rd_q;
    wb_valid_d  = wb_valid_q;
    wb_rw_d     = wb_rw_q;
    wb_mtr_d    = wb_mtr_q;
    wb_rd_d     = wb_rd_q;

    if (!bus.hold) begin
      if (bus.ex_redirect || stall_w) begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = 9'd0;
        ex_rs1_d   = 5'd0;
        ex_rs2_d   = 5'd0;
        ex_rd_d    = 5'd0;
      end else begin
        ex_valid_d = bus.id_valid;
        ex_ctrl_d  = bus.id_ctrl;
        ex_rs1_d   = bus.id_rs1;
        ex_rs2_d   = bus.id_rs2;
        ex_rd_d    = bus.id_rd;
        // Writes to x0 are discarded at capture so later stages never
        // forward or write back a value for it.
        if (bus.id_rd == 5'd0) begin
          ex_ctrl_d[8] = 1'b0;
        end
      end

      mem_valid_d = ex_valid_q;
      mem_rw_d    = ex_valid_q & ex_ctrl_q[8];
      mem_mr_d    = ex_valid_q & ex_ctrl_q[7];
      mem_mw_d    = ex_valid_q & ex_ctrl_q[6];
      mem_mtr_d   = ex_valid_q & ex_ctrl_q[5];
      mem_rd_d    = ex_rd_q;

      wb_valid_d  = mem_valid_q;
      wb_rw_d     = mem_valid_q & mem_rw_q;
      wb_mtr_d    = mem_valid_q & mem_mtr_q;
      wb_rd_d     = mem_rd_q;
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= 9'd0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      ex_rd_q     <= 5'd0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_mr_q    <= 1'b0;
      mem_mw_q    <= 1'b0;
      mem_mtr_q   <= 1'b0;
      mem_rd_q    <= 5'd0;
      wb_valid_q  <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_mtr_q    <= 1'b0;
      wb_rd_q     <= 5'd0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_rd_q     <= ex_rd_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_mr_q    <= mem_mr_d;
      mem_mw_q    <= mem_mw_d;
      mem_mtr_q   <= mem_mtr_d;
      mem_rd_q    <= mem_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_rw_q     <= wb_rw_d;
      wb_mtr_q    <= wb_mtr_d;
      wb_rd_q     <= wb_rd_d;
    end
  end

  // Stage outputs; every control bit is qualified by its stage valid.
  always_comb begin
    mem_reg_write_w = mem_valid_q & mem_rw_q;
    wb_reg_write_w  = wb_valid_q & wb_rw_q;

    bus.stall          = stall_w;
    bus.ex_valid       = ex_valid_q;
    bus.ex_ctrl        = ex_valid_q ? ex_ctrl_q : 9'd0;
    bus.ex_rs1         = ex_rs1_q;
    bus.ex_rs2         = ex_rs2_q;
    bus.ex_rd          = ex_rd_q;
    bus.mem_valid      = mem_valid_q;
    bus.mem_reg_write  = mem_reg_write_w;
    bus.mem_mem_read   = mem_valid_q & mem_mr_q;
    bus.mem_mem_write  = mem_valid_q & mem_mw_q;
    bus.mem_mem_to_reg = mem_valid_q & mem_mtr_q;
    bus.mem_rd         = mem_rd_q;
    bus.wb_valid       = wb_valid_q;
    bus.wb_reg_write   = wb_reg_write_w;
    bus.wb_mem_to_reg  = wb_valid_q & wb_mtr_q;
    bus.wb_rd          = wb_rd_q;
  end

  // Forwarding selects: the younger producer in MEM beats the older one in WB.
  always_comb begin
    bus.fwd_a = 2'b00;
    bus.fwd_b = 2'b00;
    if (ex_valid_q) begin
      if (mem_reg_write_w && (mem_rd_q != 5'd0) && (mem_rd_q == ex_rs1_q)) begin
        bus.fwd_a = 2'b10;
      end else if (wb_reg_write_w && (wb_rd_q != 5'd0) && (wb_rd_q == ex_rs1_q)) begin
        bus.fwd_a = 2'b01;
      end
      if (mem_reg_write_w && (mem_rd_q != 5'd0) && (mem_rd_q == ex_rs2_q)) begin
        bus.fwd_b = 2'b10;
      end else if (wb_reg_write_w && (wb_rd_q != 5'd0) && (wb_rd_q == ex_rs2_q)) begin
        bus.fwd_b = 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe
// Directed bench for ctrl_pipe. A stage-slot model (one instruction record per
// stage) predicts every output; a negedge process compares the DUT against it
// each cycle, and the stimulus sequence adds hand-computed literal checks.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       v;
    logic [8:0] c;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instrT;

  localparam logic [8:0] CTRL_ALU = 9'h102;
  localparam logic [8:0] CTRL_LW  = 9'h1B0;
  localparam logic [8:0] CTRL_BR  = 9'h009;
  localparam logic [8:0] CTRL_LWX = 9'b111011000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic checkEn = 1'b0;
  int   checkCount = 0;
  int   errorCount = 0;

  instrT mEx  = '0;
  instrT mMem = '0;
  instrT mWb  = '0;

  ctrl_pipe_if bus ();

  ctrl_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Comparison helper used by both the per-cycle compare and literal checks
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Spec-level rules evaluated on the model's stage records
  function automatic logic modelStall();
    return bus.id_valid && mEx.v && mEx.c[7] && (mEx.rd != 0) &&
           ((mEx.rd == bus.id_rs1) || (mEx.rd == bus.id_rs2)) && !bus.ex_redirect;
  endfunction

  function automatic logic [1:0] modelFwd(input logic [4:0] rs);
    if (!mEx.v) return 2'b00;
    if (mMem.v && mMem.c[8] && mMem.rd != 0 && mMem.rd == rs) return 2'b10;
    if (mWb.v && mWb.c[8] && mWb.rd != 0 && mWb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Model advance: each stage slot inherits the older slot's instruction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mEx  = '0;
      mMem = '0;
      mWb  = '0;
    end else if (!bus.hold) begin
      logic bubble;
      bubble = bus.ex_redirect || modelStall();
      mWb  = mMem;
      mMem = mEx;
      if (bubble) begin
        mEx = '0;
      end else begin
        mEx = '{bus.id_valid, bus.id_ctrl, bus.id_rs1, bus.id_rs2, bus.id_rd};
        if (bus.id_rd == 0) mEx.c[8] = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("stall", bus.stall, modelStall());
      checkOutput("ex_valid", bus.ex_valid, mEx.v);
      checkOutput("ex_ctrl", bus.ex_ctrl, mEx.v ? mEx.c : 9'd0);
      checkOutput("mem_valid", bus.mem_valid, mMem.v);
      checkOutput("mem_reg_write", bus.mem_reg_write, mMem.v & mMem.c[8]);
      checkOutput("mem_mem_read", bus.mem_mem_read, mMem.v & mMem.c[7]);
      checkOutput("mem_mem_write", bus.mem_mem_write, mMem.v & mMem.c[6]);
      checkOutput("mem_mem_to_reg", bus.mem_mem_to_reg, mMem.v & mMem.c[5]);
      checkOutput("wb_valid", bus.wb_valid, mWb.v);
      checkOutput("wb_reg_write", bus.wb_reg_write, mWb.v & mWb.c[8]);
      checkOutput("wb_mem_to_reg", bus.wb_mem_to_reg, mWb.v & mWb.c[5]);
      checkOutput("fwd_a", bus.fwd_a, modelFwd(mEx.rs1));
      checkOutput("fwd_b", bus.fwd_b, modelFwd(mEx.rs2));
      if (mEx.v) begin
        checkOutput("ex_rs1", bus.ex_rs1, mEx.rs1);
        checkOutput("ex_rs2", bus.ex_rs2, mEx.rs2);
        checkOutput("ex_rd", bus.ex_rd, mEx.rd);
      end
      if (mMem.v) checkOutput("mem_rd", bus.mem_rd, mMem.rd);
      if (mWb.v)  checkOutput("wb_rd", bus.wb_rd, mWb.rd);
    end
  end

  // Drive ID-side inputs and let combinational outputs settle
  task automatic applyStimulus(input logic v, input logic [8:0] c, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic redir, input logic hld);
    bus.id_valid    = v;
    bus.id_ctrl     = c;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.ex_redirect = redir;
    bus.hold        = hld;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      stepClock();
    end
  endtask

  initial begin
    applyStimulus(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkEn = 1'b1;
    stepClock();
    stepClock();

    $display("[TB] reset state");
    checkOutput("rst_ex_valid", bus.ex_valid, 0);
    checkOutput("rst_mem_valid", bus.mem_valid, 0);
    checkOutput("rst_stall", bus.stall, 0);
    checkOutput("rst_fwd_a", bus.fwd_a, 0);
    checkOutput("rst_wb_rd", bus.wb_rd, 0);
    reset = 1'b0;

    $display("[TB] forwarding");
    applyStimulus(1'b1, CTRL_ALU, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, CTRL_ALU, 5'd5, 5'd3, 5'd6, 1'b0, 1'b0);
    stepClock();
    checkOutput("fwd_mem_a", bus.fwd_a, 2'b10);
    applyStimulus(1'b1, CTRL_ALU, 5'd5, 5'd4, 5'd7, 1'b0, 1'b0);
    stepClock();
    checkOutput("fwd_wb_a", bus.fwd_a, 2'b01);
    applyStimulus(1'b1, CTRL_ALU, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    stepClock();
    checkOutput("x0_ctrl", bus.ex_ctrl, 9'h002);
    applyStimulus(1'b1, CTRL_ALU, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
    stepClock();
    checkOutput("fwd_x0_a", bus.fwd_a, 2'b00);
    idle(3);

    $display("[TB] load-use");
    applyStimulus(1'b1, CTRL_LW, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, CTRL_ALU, 5'd2, 5'd7, 5'd8, 1'b0, 1'b0);
    checkOutput("lu_stall", bus.stall, 1);
    stepClock();
    checkOutput("lu_bubble", bus.ex_valid, 0);
    checkOutput("lu_mem_read", bus.mem_mem_read, 1);
    applyStimulus(1'b1, CTRL_ALU, 5'd2, 5'd7, 5'd8, 1'b0, 1'b0);
    checkOutput("lu_stall_clear", bus.stall, 0);
    stepClock();
    checkOutput("lu_fwd_b", bus.fwd_b, 2'b01);
    checkOutput("lu_ex_rd", bus.ex_rd, 5'd8);
    idle(3);

    $display("[TB] redirect");
    applyStimulus(1'b1, CTRL_BR, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, CTRL_LWX, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0);
    stepClock();
    checkOutput("rd_ex_valid", bus.ex_valid, 0);
    checkOutput("rd_ex_ctrl", bus.ex_ctrl, 0);
    checkOutput("rd_mem_valid", bus.mem_valid, 1);
    idle(3);

    $display("[TB] redirect with load-use");
    applyStimulus(1'b1, CTRL_LW, 5'd1, 5'd0, 5'd10, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, CTRL_ALU, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0);
    checkOutput("rl_stall", bus.stall, 0);
    stepClock();
    checkOutput("rl_bubble", bus.ex_valid, 0);
    applyStimulus(1'b1, CTRL_ALU, 5'd11, 5'd0, 5'd12, 1'b0, 1'b0);
    stepClock();
    checkOutput("rl_resume", bus.ex_valid, 1);
    checkOutput("rl_ex_rd", bus.ex_rd, 5'd12);
    idle(3);

    $display("[TB] hold");
    applyStimulus(1'b1, CTRL_ALU, 5'd1, 5'd2, 5'd13, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, CTRL_ALU, 5'd3, 5'd4, 5'd14, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, CTRL_ALU, 5'd13, 5'd0, 5'd15, 1'b0, 1'b0);
    stepClock();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, CTRL_ALU, 5'd15, 5'd14, 5'd16, 1'b0, 1'b1);
      stepClock();
    end
    checkOutput("hold_ex_rd", bus.ex_rd, 5'd15);
    checkOutput("hold_mem_rd", bus.mem_rd, 5'd14);
    checkOutput("hold_wb_rd", bus.wb_rd, 5'd13);
    checkOutput("hold_fwd_a", bus.fwd_a, 2'b01);
    applyStimulus(1'b1, CTRL_ALU, 5'd15, 5'd14, 5'd16, 1'b0, 1'b0);
    stepClock();
    checkOutput("rel_ex_rd", bus.ex_rd, 5'd16);
    checkOutput("rel_mem_rd", bus.mem_rd, 5'd15);
    checkOutput("rel_wb_rd", bus.wb_rd, 5'd14);
    checkOutput("rel_fwd_a", bus.fwd_a, 2'b10);
    checkOutput("rel_fwd_b", bus.fwd_b, 2'b01);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, CTRL_ALU, 5'd1, 5'd2, 5'd17, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("mr_ex_valid", bus.ex_valid, 0);
    checkOutput("mr_mem_valid", bus.mem_valid, 0);
    checkOutput("mr_wb_valid", bus.wb_valid, 0);
    checkOutput("mr_ex_ctrl", bus.ex_ctrl, 0);
    checkOutput("mr_mem_rw", bus.mem_reg_write, 0);
    checkOutput("mr_wb_rw", bus.wb_reg_write, 0);
    stepClock();
    reset = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
